bitplane_address_generator: RTL and testbench

Pixel-rate address sequencer that sits directly upstream of the bitplane-to-raster stage. Walks a bitmap in GPU RAM according to colour mode, byte mode, horizontal/vertical pixel scaling and line stride. Issues one read address per active pixel tick. Delays the matching control fields (x, colour mode, pixel enable) so they arrive at the raster stage aligned with the returned RAM data.

---
 rtl/bitplane_address_generator_if.sv | 29 ++
 rtl/bitplane_address_generator.sv | 180 ++++++++++++++++++
 tb/tb_bitplane_address_generator.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bitplane_address_generator_if.sv
// RAM read bus and raster-side control outputs of the bitplane address generator.
interface bitplane_address_generator_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_req;
    logic              pixel_out_ena;
    logic [9:0]        x_out;
    logic [2:0]        colour_mode_out;
    logic              two_byte_mode_out;

    modport master (
        output ram_addr,
        output ram_rd_req,
        output pixel_out_ena,
        output x_out,
        output colour_mode_out,
        output two_byte_mode_out
    );

    modport slave (
        input ram_addr,
        input ram_rd_req,
        input pixel_out_ena,
        input x_out,
        input colour_mode_out,
        input two_byte_mode_out
    );
endinterface

// File: rtl/bitplane_address_generator.sv
// Pixel-rate bitmap address sequencer with a control-field delay line
// that realigns x/mode/enable with the returning RAM data.
module bitplane_address_generator #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        pc_ena,
    input  logic              hde,
    input  logic              vde,
    input  logic              frame_start,
    input  logic              bitplane_ena,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [15:0]       bytes_per_line,
    input  logic [3:0]        h_scale,
    input  logic [3:0]        v_scale,
    input  logic [2:0]        colour_mode_in,
    input  logic              two_byte_mode_in,
    bitplane_address_generator_if.master bus
);

    typedef struct packed {
        logic       act;
        logic [6:0] byte_idx;
        logic [2:0] x_sub;
        logic [2:0] mode;
        logic       two;
    } ctl_t;

    localparam ctl_t IDLE = '{
        act: 1'b0, byte_idx: 7'd0, x_sub: 3'd0,
        mode: 3'b100, two: 1'b0
    };

    logic              hde_d;
    logic              armed;
    logic [ADDR_W-1:0] line_base;
    logic [3:0]        v_cnt;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        x_sub;
    logic [6:0]        byte_idx;
    logic [3:0]        h_cnt;
    logic [3:0]        h_scale_l;
    logic [3:0]        v_scale_l;
    logic [2:0]        mode_l;
    logic              two_l;
    logic              ena_l;
    logic [ADDR_W-1:0] addr_q;
    ctl_t              iss;
    ctl_t              pipe [MEM_LATENCY];

    logic              tick;
    logic              line_start;
    logic              line_end;
    logic              active;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        cur_xsub;
    logic [6:0]        cur_byte;
    logic [3:0]        cur_h;
    logic [3:0]        cur_hs;
    logic [2:0]        cur_mode;
    logic              cur_two;
    logic              cur_en;
    logic [3:0]        step;
    logic [3:0]        sum;
    logic [ADDR_W-1:0] n_addr;
    logic [2:0]        n_xsub;
    logic [6:0]        n_byte;
    logic [3:0]        n_h;

    assign tick       = (pc_ena == 4'h0);
    assign line_start = hde & ~hde_d;
    assign line_end   = ~hde & hde_d;

    // On the line_start tick the first fetch already uses the freshly
    // loaded line state, so the walk starts on the first hde pixel.
    always_comb begin
        cur_addr = addr;
        cur_xsub = x_sub;
        cur_byte = byte_idx;
        cur_h    = h_cnt;
        cur_hs   = h_scale_l;
        cur_mode = mode_l;
        cur_two  = two_l;
        cur_en   = ena_l;
        if (line_start) begin
            cur_addr = frame_start ? base_address : line_base;
            cur_xsub = 3'd0;
            cur_byte = 7'd0;
            cur_h    = 4'd0;
            cur_hs   = h_scale;
            cur_mode = colour_mode_in;
            cur_two  = two_byte_mode_in;
            cur_en   = bitplane_ena;
        end
        active = armed & hde & vde & cur_en & ~cur_mode[2];
        step   = 4'd1 << cur_mode[1:0];
        sum    = {1'b0, cur_xsub} + step;
        n_addr = cur_addr;
        n_xsub = cur_xsub;
        n_byte = cur_byte;
        n_h    = cur_h;
        if (active) begin
            if (cur_h == cur_hs) begin
                n_h    = 4'd0;
                n_xsub = sum[2:0];
                if (sum[3]) begin
                    n_byte = cur_byte + 7'd1;
                    n_addr = cur_addr
                           + {{(ADDR_W-2){1'b0}}, cur_two, ~cur_two};
                end
            end else begin
                n_h = cur_h + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hde_d     <= 1'b0;
            armed     <= 1'b0;
            line_base <= '0;
            v_cnt     <= 4'd0;
            addr      <= '0;
            x_sub     <= 3'd0;
            byte_idx  <= 7'd0;
            h_cnt     <= 4'd0;
            h_scale_l <= 4'd0;
            v_scale_l <= 4'd0;
            mode_l    <= 3'b100;
            two_l     <= 1'b0;
            ena_l     <= 1'b0;
            addr_q    <= '0;
            iss       <= IDLE;
            for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= IDLE;
        end else if (tick) begin
            hde_d    <= hde;
            addr     <= n_addr;
            x_sub    <= n_xsub;
            byte_idx <= n_byte;
            h_cnt    <= n_h;
            if (line_start) begin
                h_scale_l <= h_scale;
                v_scale_l <= v_scale;
                mode_l    <= colour_mode_in;
                two_l     <= two_byte_mode_in;
                ena_l     <= bitplane_ena;
            end
            if (frame_start) begin
                armed     <= 1'b1;
                line_base <= base_address;
                v_cnt     <= 4'd0;
            end else if (line_end) begin
                if (v_cnt == v_scale_l) begin
                    line_base <= line_base + ADDR_W'(bytes_per_line);
                    v_cnt     <= 4'd0;
                end else begin
                    v_cnt <= v_cnt + 4'd1;
                end
            end
            if (active) addr_q <= cur_addr;
            iss <= active ? '{act: 1'b1, byte_idx: cur_byte,
                              x_sub: cur_xsub, mode: cur_mode,
                              two: cur_two}
                          : IDLE;
            pipe[0] <= iss;
            for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.ram_addr          = addr_q;
    assign bus.ram_rd_req        = iss.act;
    assign bus.pixel_out_ena     = pipe[MEM_LATENCY-1].act;
    assign bus.x_out             = {pipe[MEM_LATENCY-1].byte_idx,
                                    pipe[MEM_LATENCY-1].x_sub};
    assign bus.colour_mode_out   = pipe[MEM_LATENCY-1].mode;
    assign bus.two_byte_mode_out = pipe[MEM_LATENCY-1].two;

endmodule

// File: tb/tb_bitplane_address_generator.sv
// Randomized bench: two DUTs (latency 1 and 3) against a pixel-index
// arithmetic model of the bitmap walk.
module tb_bitplane_address_generator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  pc_ena;
    logic        hde;
    logic        vde;
    logic        frame_start;
    logic        bitplane_ena;
    logic [19:0] base_address;
    logic [15:0] bytes_per_line;
    logic [3:0]  h_scale;
    logic [3:0]  v_scale;
    logic [2:0]  colour_mode_in;
    logic        two_byte_mode_in;

    bitplane_address_generator_if #(.ADDR_W(20)) bus1 ();
    bitplane_address_generator_if #(.ADDR_W(20)) bus3 ();

    bitplane_address_generator #(.MEM_LATENCY(1), .ADDR_W(20)) dut1 (
        .clk(clk), .reset_n(reset_n), .pc_ena(pc_ena), .hde(hde),
        .vde(vde), .frame_start(frame_start),
        .bitplane_ena(bitplane_ena), .base_address(base_address),
        .bytes_per_line(bytes_per_line), .h_scale(h_scale),
        .v_scale(v_scale), .colour_mode_in(colour_mode_in),
        .two_byte_mode_in(two_byte_mode_in), .bus(bus1.master)
    );

    bitplane_address_generator #(.MEM_LATENCY(3), .ADDR_W(20)) dut3 (
        .clk(clk), .reset_n(reset_n), .pc_ena(pc_ena), .hde(hde),
        .vde(vde), .frame_start(frame_start),
        .bitplane_ena(bitplane_ena), .base_address(base_address),
        .bytes_per_line(bytes_per_line), .h_scale(h_scale),
        .v_scale(v_scale), .colour_mode_in(colour_mode_in),
        .two_byte_mode_in(two_byte_mode_in), .bus(bus3.master)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // model: {act, x[9:0], mode[2:0], two}
    localparam logic [14:0] IDLE = {1'b0, 10'd0, 3'b100, 1'b0};

    bit          m_armed;
    bit          m_hprev;
    int          m_line;
    logic [19:0] m_fbase;
    int          l_p;
    int          l_hs;
    logic [2:0]  l_mode;
    bit          l_two;
    bit          l_en;
    logic [19:0] l_base;
    logic [19:0] e_addr;
    bit          e_req;
    logic [14:0] hist [5];

    task automatic model_reset();
        m_armed = 0; m_hprev = 0; m_line = 0; m_fbase = '0;
        l_p = 0; l_hs = 0; l_mode = 3'b100; l_two = 0; l_en = 0;
        l_base = '0; e_addr = '0; e_req = 0;
        for (int i = 0; i < 5; i++) hist[i] = IDLE;
    endtask

    task automatic model_tick();
        bit ls, le, act;
        int src, bits, bi;
        logic [14:0] r;
        ls = hde && !m_hprev;
        le = !hde && m_hprev;
        if (frame_start) begin
            m_fbase = base_address;
            m_line  = 0;
        end else if (le) begin
            m_line++;
        end
        if (ls) begin
            l_hs   = int'(h_scale);
            l_mode = colour_mode_in;
            l_two  = two_byte_mode_in;
            l_en   = bitplane_ena;
            l_p    = 0;
            l_base = 20'(int'(m_fbase) + (m_line / (int'(v_scale) + 1))
                         * int'(bytes_per_line));
        end
        act = m_armed && hde && vde && l_en && !l_mode[2];
        r = IDLE;
        if (act) begin
            src    = l_p / (l_hs + 1);
            bits   = src * (1 << l_mode[1:0]);
            bi     = bits / 8;
            e_addr = 20'(int'(l_base) + bi * (l_two ? 2 : 1));
            r      = {1'b1, 7'(bi), 3'(bits % 8), l_mode, l_two};
            l_p++;
        end
        e_req = act;
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = r;
        if (frame_start) m_armed = 1;
        m_hprev = hde;
    endtask

    function automatic logic [14:0] outs(input logic p,
        input logic [9:0] x, input logic [2:0] m, input logic t);
        return {p, x, m, t};
    endfunction

    task automatic tick(input bit h, input bit v, input bit fs);
        hde = h; vde = v; frame_start = fs;
        repeat (2) begin
            pc_ena = 4'($urandom_range(1, 15));
            @(negedge clk);
        end
        chk("hold_addr1", 32'(bus1.ram_addr), 32'(e_addr));
        pc_ena = 4'h0;
        @(posedge clk);
        #1;
        model_tick();
        chk("req1", 32'(bus1.ram_rd_req), 32'(e_req));
        chk("addr1", 32'(bus1.ram_addr), 32'(e_addr));
        chk("ctl1", 32'(outs(bus1.pixel_out_ena, bus1.x_out,
            bus1.colour_mode_out, bus1.two_byte_mode_out)),
            32'(hist[1]));
        chk("req3", 32'(bus3.ram_rd_req), 32'(e_req));
        chk("addr3", 32'(bus3.ram_addr), 32'(e_addr));
        chk("ctl3", 32'(outs(bus3.pixel_out_ena, bus3.x_out,
            bus3.colour_mode_out, bus3.two_byte_mode_out)),
            32'(hist[3]));
        @(negedge clk);
    endtask

    task automatic jitter();
        h_scale          = 4'($urandom_range(0, 3));
        colour_mode_in   = 3'($urandom_range(0, 7));
        two_byte_mode_in = 1'($urandom_range(0, 1));
        bitplane_ena     = ($urandom_range(0, 5) != 0);
        base_address     = 20'($urandom);
    endtask

    task automatic run_line(input int blank, input int act,
                            input bit v, input int fs_at, input bit jit);
        for (int i = 0; i < blank; i++) tick(0, v, i == fs_at);
        for (int i = 0; i < act; i++) begin
            if (jit && $urandom_range(0, 5) == 0) jitter();
            tick(1, v, 0);
        end
    endtask

    task automatic set_cfg(input logic [19:0] b, input logic [2:0] m,
        input bit t, input logic [3:0] hs, input logic [3:0] vs,
        input logic [15:0] bpl, input bit en);
        base_address = b; colour_mode_in = m; two_byte_mode_in = t;
        h_scale = hs; v_scale = vs; bytes_per_line = bpl;
        bitplane_ena = en;
    endtask

    task automatic frame(input int lines, input int act, input int fs_at,
                         input bit jit);
        for (int l = 0; l < lines; l++)
            run_line(3, act, 1, (l == 0) ? fs_at : -1, jit);
    endtask

    task automatic chk_reset(input string s);
        chk({s, "_addr1"}, 32'(bus1.ram_addr), 32'h0);
        chk({s, "_req1"}, 32'(bus1.ram_rd_req), 32'h0);
        chk({s, "_ctl1"}, 32'(outs(bus1.pixel_out_ena, bus1.x_out,
            bus1.colour_mode_out, bus1.two_byte_mode_out)), 32'(IDLE));
        chk({s, "_req3"}, 32'(bus3.ram_rd_req), 32'h0);
        chk({s, "_ctl3"}, 32'(outs(bus3.pixel_out_ena, bus3.x_out,
            bus3.colour_mode_out, bus3.two_byte_mode_out)), 32'(IDLE));
    endtask

    initial begin
        reset_n = 1'b0;
        pc_ena = 4'h1; hde = 0; vde = 0; frame_start = 0;
        set_cfg(20'h0, 3'b000, 0, 4'd0, 4'd0, 16'd16, 1);
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // unarmed lines: no fetch before the first frame_start
        frame(1, 6, -1, 0);

        set_cfg(20'h01000, 3'b000, 0, 4'd0, 4'd0, 16'd16, 1);
        frame(2, 16, 1, 0);

        set_cfg(20'h01000, 3'b011, 1, 4'd1, 4'd0, 16'd16, 1);
        frame(2, 6, 1, 0);

        set_cfg(20'h00000, 3'b001, 0, 4'd0, 4'd2, 16'd80, 1);
        frame(7, 4, 1, 0);

        set_cfg(20'hFFFFF, 3'b011, 0, 4'd0, 4'd0, 16'd16, 1);
        frame(2, 4, 1, 0);
        // frame_start on the hde falling tick: no stride step
        frame(2, 4, 0, 0);

        set_cfg(20'h02000, 3'b110, 0, 4'd0, 4'd0, 16'd16, 1);
        frame(2, 6, 1, 0);
        set_cfg(20'h02000, 3'b010, 0, 4'd0, 4'd0, 16'd16, 0);
        frame(2, 6, 1, 0);

        for (int f = 0; f < 10; f++) begin
            set_cfg(20'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)),
                    16'($urandom), 1);
            for (int l = 0; l < 6; l++)
                run_line($urandom_range(2, 4), $urandom_range(6, 20),
                         $urandom_range(0, 7) != 0, (l == 0) ? 1 : -1, 1);
        end

        // reset in the middle of an active line
        set_cfg(20'h03000, 3'b001, 0, 4'd0, 4'd0, 16'd40, 1);
        frame(1, 5, 1, 0);
        run_line(3, 5, 1, -1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        run_line(0, 6, 1, -1, 0);
        frame(1, 6, -1, 0);
        frame(3, 8, 1, 0);
        run_line(3, 0, 1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
